// File: rtl/ysyx_23060191_div_ctrl.sv
// Multi-cycle restoring divider sequencer for RV32M DIV/DIVU/REM/REMU.
// Define YSYX_23060191_DIV_FASTPATH_EN to resolve divide-by-zero/overflow on the accept edge.
module ysyx_23060191_div_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_src1,
   input  logic [WIDTH-1:0] i_src2,
   input  logic             i_flush,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_res,
   output logic             o_busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      FIX,
      DONE
   } state_t;

   state_t           state, next_state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem_q, quo_q, div_q, src1_q;
   logic [1:0]       op_q;
   logic             sign_q, sign_r, div_zero_q, ovf_q;

   logic             accept, fast_hit;
   logic             in_signed, in_s1, in_s2, in_div_zero, in_ovf;
   logic [WIDTH-1:0] in_mag1, in_mag2, in_corner;
   logic [WIDTH:0]   rem_sh, trial;
   logic [WIDTH-1:0] fix_res, quo_fix, rem_fix, fix_corner;

   // Divide-by-zero yields all ones / dividend; signed overflow yields MIN_INT / zero.
   function automatic logic [WIDTH-1:0] corner_res(input logic [1:0] op,
                                                   input logic [WIDTH-1:0] src1,
                                                   input logic div_zero);
      if (div_zero)
         corner_res = op[1] ? src1 : '1;
      else
         corner_res = op[1] ? '0 : MIN_INT;
   endfunction

   assign accept      = (state == IDLE) && i_valid && !i_flush;
   assign in_signed   = !i_op[0];
   assign in_s1       = in_signed && i_src1[WIDTH-1];
   assign in_s2       = in_signed && i_src2[WIDTH-1];
   assign in_mag1     = in_s1 ? (~i_src1 + 1'b1) : i_src1;
   assign in_mag2     = in_s2 ? (~i_src2 + 1'b1) : i_src2;
   assign in_div_zero = (i_src2 == '0);
   assign in_ovf      = in_signed && (i_src1 == MIN_INT) && (i_src2 == '1);
   assign in_corner   = corner_res(i_op, i_src1, in_div_zero);

`ifdef YSYX_23060191_DIV_FASTPATH_EN
   assign fast_hit = in_div_zero || in_ovf;
`else
   assign fast_hit = 1'b0;
`endif

   // The trial subtraction fits WIDTH+1 bits because the partial remainder stays below the divisor.
   assign rem_sh = {rem_q, quo_q[WIDTH-1]};
   assign trial  = rem_sh - {1'b0, div_q};

   assign quo_fix    = (!op_q[0] && sign_q) ? (~quo_q + 1'b1) : quo_q;
   assign rem_fix    = (!op_q[0] && sign_r) ? (~rem_q + 1'b1) : rem_q;
   assign fix_corner = corner_res(op_q, src1_q, div_zero_q);
   assign fix_res    = (div_zero_q || ovf_q) ? fix_corner : (op_q[1] ? rem_fix : quo_fix);

   assign o_ready = (state == IDLE);
   assign o_busy  = (state != IDLE);
   assign o_valid = (state == DONE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: if (accept) next_state = fast_hit ? DONE : BUSY;
         BUSY: if (cnt == '0) next_state = FIX;
         FIX:  next_state = DONE;
         DONE: if (i_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (i_flush)
         next_state = IDLE;
   end

   // Datapath: operand capture, one restoring step per BUSY edge, result write in FIX.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt        <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         div_q      <= '0;
         src1_q     <= '0;
         op_q       <= '0;
         sign_q     <= 1'b0;
         sign_r     <= 1'b0;
         div_zero_q <= 1'b0;
         ovf_q      <= 1'b0;
         o_res      <= '0;
      end else if (accept) begin
         cnt        <= CNT_W'(WIDTH - 1);
         rem_q      <= '0;
         quo_q      <= in_mag1;
         div_q      <= in_mag2;
         src1_q     <= i_src1;
         op_q       <= i_op;
         sign_q     <= in_s1 ^ in_s2;
         sign_r     <= in_s1;
         div_zero_q <= in_div_zero;
         ovf_q      <= in_ovf;
         if (fast_hit)
            o_res <= in_corner;
      end else if (!i_flush) begin
         if (state == BUSY) begin
            rem_q <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], !trial[WIDTH]};
            if (cnt != '0)
               cnt <= cnt - 1'b1;
         end else if (state == FIX) begin
            o_res <= fix_res;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060191_div_ctrl.sv
// Directed self-checking bench for ysyx_23060191_div_ctrl (default or fast-path build).
module tb_ysyx_23060191_div_ctrl;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;
   localparam int NORMAL_LAT = 34;
`ifdef YSYX_23060191_DIV_FASTPATH_EN
   localparam int CORNER_LAT = 1;
`else
   localparam int CORNER_LAT = 34;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [1:0]  i_op = 2'b00;
   logic [31:0] i_src1 = '0;
   logic [31:0] i_src2 = '0;
   logic        i_flush = 1'b0;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [31:0] o_res;
   logic        o_busy;

   int          checkCount = 0;
   int          passCount = 0;
   logic [31:0] lastRes = '0;

   ysyx_23060191_div_ctrl #(.WIDTH(32)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_op    (i_op),
      .i_src1  (i_src1),
      .i_src2  (i_src2),
      .i_flush (i_flush),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_res   (o_res),
      .o_busy  (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
   endtask

   // Issue one request, measure edges to o_valid (accept edge counts as 1), optionally stall the WBU.
   task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] expRes,
                                input int expLat, input int hold);
      int  lat;
      logic stable;
      @(negedge i_clk);
      i_valid = 1'b1;
      i_op    = op;
      i_src1  = a;
      i_src2  = b;
      @(posedge i_clk);
      lat = 1;
      #1;
      i_valid = 1'b0;
      while (!o_valid && lat < 200) begin
         @(posedge i_clk);
         lat++;
         #1;
      end
      checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
      checkOutput({tag, "_res"}, o_res, expRes);
      lastRes = expRes;
      if (hold > 0) begin
         stable = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(posedge i_clk);
            #1;
            if (!o_valid || o_ready || o_res !== expRes)
               stable = 1'b0;
         end
         checkOutput({tag, "_hold_stable"}, 32'(stable), 32'd1);
      end
      @(negedge i_clk);
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      i_ready = 1'b0;
      checkOutput({tag, "_rel_valid"}, 32'(o_valid), 32'd0);
      checkOutput({tag, "_rel_ready"}, 32'(o_ready), 32'd1);
   endtask

   initial begin
      #1;
      checkOutput("rst_busy", 32'(o_busy), 32'd0);
      checkOutput("rst_valid", 32'(o_valid), 32'd0);
      checkOutput("rst_res", o_res, 32'd0);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;
      checkOutput("idle_ready", 32'(o_ready), 32'd1);

      applyStimulus("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, NORMAL_LAT, 10);
      applyStimulus("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, NORMAL_LAT, 0);
      applyStimulus("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORMAL_LAT, 0);
      applyStimulus("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NORMAL_LAT, 0);
      applyStimulus("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, NORMAL_LAT, 0);
      applyStimulus("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, NORMAL_LAT, 0);
      applyStimulus("divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, NORMAL_LAT, 0);
      applyStimulus("remu_min_m1", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, NORMAL_LAT, 0);
      applyStimulus("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, CORNER_LAT, 0);
      applyStimulus("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, CORNER_LAT, 0);
      applyStimulus("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, CORNER_LAT, 0);
      applyStimulus("rem_m5_0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, CORNER_LAT, 0);
      applyStimulus("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, CORNER_LAT, 0);
      applyStimulus("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, CORNER_LAT, 0);

      // Flush at cnt=15 together with a new request: neither operation survives.
      @(negedge i_clk);
      i_valid = 1'b1;
      i_op    = OP_DIVU;
      i_src1  = 32'd100;
      i_src2  = 32'd7;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      repeat (16) @(posedge i_clk);
      @(negedge i_clk);
      i_flush = 1'b1;
      i_valid = 1'b1;
      i_src1  = 32'd50;
      i_src2  = 32'd5;
      @(posedge i_clk);
      #1;
      i_flush = 1'b0;
      i_valid = 1'b0;
      checkOutput("flush_busy", 32'(o_busy), 32'd0);
      checkOutput("flush_valid", 32'(o_valid), 32'd0);
      checkOutput("flush_res_kept", o_res, lastRes);
      @(posedge i_clk);
      #1;
      checkOutput("flush_no_accept", 32'(o_busy), 32'd0);
      applyStimulus("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, NORMAL_LAT, 0);

      // Async reset at cnt=5.
      @(negedge i_clk);
      i_valid = 1'b1;
      i_op    = OP_REMU;
      i_src1  = 32'd100;
      i_src2  = 32'd7;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      repeat (26) @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b0;
      #1;
      checkOutput("arst_busy", 32'(o_busy), 32'd0);
      checkOutput("arst_valid", 32'(o_valid), 32'd0);
      checkOutput("arst_res", o_res, 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      applyStimulus("post_rst_divu", OP_DIVU, 32'd100, 32'd7, 32'd14, NORMAL_LAT, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
